game_hud_tracker: RTL and testbench



---
 rtl/game_pkg.sv | 43 ++++
 rtl/seg7_decode.sv | 9 +
 rtl/game_hud_tracker.sv | 96 +++++++++
 tb/tb_game_hud_tracker.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared game-state encoding, display glyphs, screen geometry and BCD helpers.
package game_pkg;
    typedef enum logic [1:0] {PLAY, SERVE_WAIT, OVER, WON} game_state_t;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    function automatic logic [6:0] seg7_glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    // Adds one BCD digit to a 3-digit BCD value, clamping at 999 instead of wrapping.
    function automatic logic [11:0] bcd_add_sat(input logic [11:0] s, input logic [3:0] p);
        logic [4:0] o, t, h;
        o = {1'b0, s[3:0]} + {1'b0, p};
        t = {1'b0, s[7:4]};
        h = {1'b0, s[11:8]};
        if (o > 5'd9) begin
            o = o - 5'd10;
            t = t + 5'd1;
        end
        if (t > 5'd9) begin
            t = t - 5'd10;
            h = h + 5'd1;
        end
        return (h > 5'd9) ? 12'h999 : {h[3:0], t[3:0], o[3:0]};
    endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-low seven-segment pattern.
module seg7_decode
    import game_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    assign seg = seg7_glyph(digit);
endmodule

// File: rtl/game_hud_tracker.sv
// game_hud_tracker: score, lives and game state tracking with registered HEX display drive.
module game_hud_tracker
    import game_pkg::*;
#(
    parameter int START_LIVES      = 3,
    parameter int POINTS_PER_BRICK = 1,
    parameter int SERVE_DELAY      = 50000000,
    parameter int DELAY_W          = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        brick_hit,
    input  logic        ball_lost,
    input  logic        all_bricks_gone,
    output logic        serve_pulse,
    output logic        game_over,
    output logic        game_won,
    output logic [3:0]  lives,
    output logic [11:0] score_bcd,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3
);
    game_state_t        state;
    logic [DELAY_W-1:0] cnt;
    logic               brick_hit_q, ball_lost_q;
    logic [6:0]         seg_0, seg_1, seg_2, seg_l;

    wire hit_rise  = brick_hit & ~brick_hit_q;
    wire lost_rise = ball_lost & ~ball_lost_q;
    wire live      = (state == PLAY) || (state == SERVE_WAIT);

    seg7_decode u_seg0 (.digit(score_bcd[3:0]),  .seg(seg_0));
    seg7_decode u_seg1 (.digit(score_bcd[7:4]),  .seg(seg_1));
    seg7_decode u_seg2 (.digit(score_bcd[11:8]), .seg(seg_2));
    seg7_decode u_segl (.digit(lives),           .seg(seg_l));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PLAY;
            lives       <= 4'(START_LIVES);
            score_bcd   <= 12'h000;
            cnt         <= '0;
            serve_pulse <= 1'b0;
            game_over   <= 1'b0;
            game_won    <= 1'b0;
            brick_hit_q <= 1'b0;
            ball_lost_q <= 1'b0;
            HEX0        <= seg7_glyph(4'd0);
            HEX1        <= seg7_glyph(4'd0);
            HEX2        <= seg7_glyph(4'd0);
            HEX3        <= seg7_glyph(4'(START_LIVES));
        end else begin
            brick_hit_q <= brick_hit;
            ball_lost_q <= ball_lost;
            serve_pulse <= 1'b0;
            HEX0        <= seg_0;
            HEX1        <= seg_1;
            HEX2        <= seg_2;
            HEX3        <= live ? seg_l : DASH;
            if (live && hit_rise)
                score_bcd <= bcd_add_sat(score_bcd, 4'(POINTS_PER_BRICK));
            case (state)
                PLAY: begin
                    // A cleared board wins even when the last ball is lost on the same cycle.
                    if (all_bricks_gone) begin
                        state    <= WON;
                        game_won <= 1'b1;
                    end else if (lost_rise && lives > 4'd1) begin
                        lives <= lives - 4'd1;
                        cnt   <= '0;
                        state <= SERVE_WAIT;
                    end else if (lost_rise) begin
                        lives     <= 4'd0;
                        state     <= OVER;
                        game_over <= 1'b1;
                    end
                end
                SERVE_WAIT: begin
                    if (all_bricks_gone) begin
                        state    <= WON;
                        game_won <= 1'b1;
                    end else if (cnt == DELAY_W'(SERVE_DELAY - 1)) begin
                        serve_pulse <= 1'b1;
                        cnt         <= '0;
                        state       <= PLAY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_game_hud_tracker.sv
// tb_game_hud_tracker: directed stimulus with a cycle-level reference model and literal spot checks.
module tb_game_hud_tracker;
    localparam int SD = 8;
    localparam int SL = 3;
    localparam int PP = 1;
    localparam int P_PLAY = 0, P_WAIT = 1, P_OVER = 2, P_WON = 3;
    localparam logic [6:0] GLYPH [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                         7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    localparam logic [6:0] DASH_G = 7'b0111111;

    logic        clk = 1'b0, rst = 1'b1;
    logic        brick_hit = 1'b0, ball_lost = 1'b0, all_bricks_gone = 1'b0;
    logic        serve_pulse, game_over, game_won;
    logic [3:0]  lives;
    logic [11:0] score_bcd;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;

    int vectors = 0, errors = 0;

    always #5 clk = ~clk;

    game_hud_tracker #(.START_LIVES(SL), .POINTS_PER_BRICK(PP), .SERVE_DELAY(SD), .DELAY_W(4)) dut (
        .clk(clk), .rst(rst), .brick_hit(brick_hit), .ball_lost(ball_lost),
        .all_bricks_gone(all_bricks_gone), .serve_pulse(serve_pulse), .game_over(game_over),
        .game_won(game_won), .lives(lives), .score_bcd(score_bcd),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int s);
        return 12'((s / 100) * 256 + ((s / 10) % 10) * 16 + s % 10);
    endfunction

    // Reference model: decimal score, life count, game phase and cycles spent waiting for a serve.
    int         m_score, m_lives, m_phase, m_waited;
    bit         m_pulse, m_valid = 0, p_hit, p_lost;
    logic [6:0] m_hex [4];

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("serve_pulse", serve_pulse, m_pulse);
            check("game_over", game_over, m_phase == P_OVER);
            check("game_won", game_won, m_phase == P_WON);
            check("lives", lives, m_lives);
            check("score_bcd", score_bcd, to_bcd(m_score));
            check("HEX0", HEX0, m_hex[0]);
            check("HEX1", HEX1, m_hex[1]);
            check("HEX2", HEX2, m_hex[2]);
            check("HEX3", HEX3, m_hex[3]);
        end
        if (rst) begin
            m_score = 0; m_lives = SL; m_phase = P_PLAY; m_waited = 0; m_pulse = 0;
            p_hit = 0; p_lost = 0;
            m_hex[0] = GLYPH[0]; m_hex[1] = GLYPH[0]; m_hex[2] = GLYPH[0]; m_hex[3] = GLYPH[SL];
            m_valid = 1;
        end else if (m_valid) begin
            bit hr, lr;
            hr = brick_hit && !p_hit;
            lr = ball_lost && !p_lost;
            m_hex[0] = GLYPH[m_score % 10];
            m_hex[1] = GLYPH[(m_score / 10) % 10];
            m_hex[2] = GLYPH[m_score / 100];
            m_hex[3] = (m_phase >= P_OVER) ? DASH_G : GLYPH[m_lives];
            m_pulse = 0;
            if (m_phase <= P_WAIT && hr) m_score = (m_score + PP > 999) ? 999 : m_score + PP;
            if (m_phase == P_PLAY) begin
                if (all_bricks_gone) m_phase = P_WON;
                else if (lr && m_lives > 1) begin m_lives--; m_phase = P_WAIT; m_waited = 0; end
                else if (lr) begin m_lives = 0; m_phase = P_OVER; end
            end else if (m_phase == P_WAIT) begin
                if (all_bricks_gone) m_phase = P_WON;
                else begin
                    m_waited++;
                    if (m_waited == SD) begin m_pulse = 1; m_phase = P_PLAY; end
                end
            end
            p_hit = brick_hit;
            p_lost = ball_lost;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic hit_pulse();
        brick_hit = 1; tick(); brick_hit = 0; tick();
    endtask

    task automatic wait_serve();
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (serve_pulse === 1'b1) seen = 1;
        end
        check("serve_seen", seen, 1);
    endtask

    task automatic lose_ball();
        ball_lost = 1; tick(); ball_lost = 0; tick();
        if (game_over !== 1'b1) wait_serve();
    endtask

    task automatic do_reset();
        rst = 1; tick(2); rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        do_reset();
        tick(10);
        check("t1_lives", lives, 3);
        check("t1_score", score_bcd, 12'h000);
        check("t1_hex0", HEX0, 7'b1000000);
        check("t1_hex3", HEX3, 7'b0110000);
        check("t1_serve", serve_pulse, 0);

        brick_hit = 1; tick(20); brick_hit = 0; tick();
        repeat (12) hit_pulse();
        check("t2_score", score_bcd, 12'h013);
        check("t2_hex1", HEX1, 7'b1111001);
        check("t2_hex0", HEX0, 7'b0110000);

        ball_lost = 1; tick();
        check("t3_lives", lives, 2);
        ball_lost = 0; tick(2);
        ball_lost = 1; tick(); ball_lost = 0; tick();
        check("t3_lives_ignored", lives, 2);
        wait_serve();
        tick();
        check("t3_pulse_one_cycle", serve_pulse, 0);

        repeat (3) lose_ball();
        tick();
        check("t4_lives", lives, 0);
        check("t4_over", game_over, 1);
        check("t4_hex3", HEX3, 7'b0111111);
        repeat (3) hit_pulse();
        check("t4_score_frozen", score_bcd, 12'h013);

        do_reset();
        tick();
        repeat (2) lose_ball();
        check("t5_lives_pre", lives, 1);
        all_bricks_gone = 1; ball_lost = 1; tick();
        check("t5_won", game_won, 1);
        check("t5_not_over", game_over, 0);
        check("t5_lives", lives, 1);
        all_bricks_gone = 0; ball_lost = 0; tick(3);

        do_reset();
        tick();
        repeat (998) hit_pulse();
        check("t6_score998", score_bcd, 12'h998);
        repeat (3) hit_pulse();
        check("t6_score_sat", score_bcd, 12'h999);
        check("t6_hex2", HEX2, 7'b0010000);
        ball_lost = 1; tick(); ball_lost = 0; tick(3);
        rst = 1; tick(); rst = 0;
        check("t6_rst_lives", lives, 3);
        check("t6_rst_score", score_bcd, 12'h000);
        check("t6_rst_hex3", HEX3, 7'b0110000);
        seen = 0;
        repeat (12) begin tick(); if (serve_pulse !== 1'b0) seen = 1; end
        check("t6_no_serve", seen, 0);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
